// File: rtl/crypt_pkg.sv
// Shared constants, stage record type and 8-bit rotation helpers for the
// four-round byte cipher.
package crypt_pkg;

  localparam int ROUNDS = 4;

  // One pipeline stage carries its own data, key and direction.
  typedef struct packed {
    logic [7:0] data;
    logic [7:0] key;
    logic       sel;
  } stage_t;

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] rotr1(input logic [7:0] x);
    return {x[0], x[7:1]};
  endfunction

  // Wrap-around left rotation by 0..3 bits: rotate a doubled copy and take
  // the upper byte.
  function automatic logic [7:0] rotl_n(input logic [7:0] x, input logic [1:0] n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

endpackage

// File: rtl/crypt_if.sv
// Round-function bus: operand, key, direction and round index in; result out.
interface crypt_if;
  logic [7:0] x;
  logic [7:0] key;
  logic       sel;
  logic [1:0] rnd;
  logic [7:0] y;

  modport master (output x, output key, output sel, output rnd, input y);
  modport slave  (input x, input key, input sel, input rnd, output y);
endinterface

// File: rtl/crypt_round.sv
// Combinational cipher round. sel=1 encrypts: rotl1(x ^ rk);
// sel=0 decrypts: rotr1(x) ^ rk. The round key is K rotated left by rnd.
module crypt_round
  import crypt_pkg::*;
(
  crypt_if.slave bus
);

  logic [7:0] w_rk;

  // Derive the round key, then apply the round in the selected direction.
  always_comb begin
    w_rk = rotl_n(bus.key, bus.rnd);
    if (bus.sel) bus.y = rotl1(bus.x ^ w_rk);
    else         bus.y = rotr1(bus.x) ^ w_rk;
  end

endmodule

// File: rtl/top.sv
// Four-stage pipelined byte cipher. Each stage applies one round and
// registers its result together with the key and direction it was given, so
// every byte in flight is processed with its own K and sel. Bytes sampled at
// edge N are on O right after edge N+3; one byte accepted per cycle.
module top
  import crypt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic i7, i6, i5, i4, i3, i2, i1, i0,
  input  logic k7, k6, k5, k4, k3, k2, k1, k0,
  output logic o7, o6, o5, o4, o3, o2, o1, o0,
  output logic high
);

  logic   [7:0]              w_d;
  logic   [7:0]              w_k;
  stage_t [ROUNDS-1:0]       w_in;
  stage_t [ROUNDS-1:0]       w_out;
  stage_t [ROUNDS-1:0]       r_stage;
  logic                      w_unused_tail;

  assign w_d = {i7, i6, i5, i4, i3, i2, i1, i0};
  assign w_k = {k7, k6, k5, k4, k3, k2, k1, k0};

  // Stage 0 takes the pins; every later stage takes its predecessor's register.
  always_comb begin
    w_in[0] = '{data: w_d, key: w_k, sel: sel};
    for (int s = 1; s < ROUNDS; s++) w_in[s] = r_stage[s-1];
  end

  for (genvar g = 0; g < ROUNDS; g++) begin : g_stage
    crypt_if u_bus ();

    // Encrypt walks rounds 0..3 down the pipe; decrypt walks 3..0.
    assign u_bus.x   = w_in[g].data;
    assign u_bus.key = w_in[g].key;
    assign u_bus.sel = w_in[g].sel;
    assign u_bus.rnd = w_in[g].sel ? 2'(g) : 2'(ROUNDS - 1 - g);

    crypt_round u_round (.bus(u_bus));

    assign w_out[g] = '{data: u_bus.y, key: w_in[g].key, sel: w_in[g].sel};
  end

  // Stage registers; reset flushes every in-flight byte, key and direction.
  always_ff @(posedge clk) begin
    if (rst) r_stage <= '0;
    else     r_stage <= w_out;
  end

  assign {o7, o6, o5, o4, o3, o2, o1, o0} = r_stage[ROUNDS-1].data;
  assign high = 1'b1;

  // Last stage's key/direction are carried for uniformity but have no consumer.
  assign w_unused_tail = ^{r_stage[ROUNDS-1].key, r_stage[ROUNDS-1].sel};

endmodule

// File: tb/tb_top.sv
// Bench for the pipelined byte cipher: directed vectors, reset flush and a
// randomized encrypt/decrypt round trip against a behavioural model.
module tb_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] o_byte;
  logic       high_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  logic [7:0] ct_q[$];
  logic [7:0] d_arr[1000];
  logic [7:0] k_arr[1000];

  crypt_if tb_bus ();

  always #5 clk = ~clk;

  top dut (
    .clk (clk), .rst (rst), .sel (tb_bus.sel),
    .i7 (tb_bus.x[7]), .i6 (tb_bus.x[6]), .i5 (tb_bus.x[5]), .i4 (tb_bus.x[4]),
    .i3 (tb_bus.x[3]), .i2 (tb_bus.x[2]), .i1 (tb_bus.x[1]), .i0 (tb_bus.x[0]),
    .k7 (tb_bus.key[7]), .k6 (tb_bus.key[6]), .k5 (tb_bus.key[5]), .k4 (tb_bus.key[4]),
    .k3 (tb_bus.key[3]), .k2 (tb_bus.key[2]), .k1 (tb_bus.key[1]), .k0 (tb_bus.key[0]),
    .o7 (o_byte[7]), .o6 (o_byte[6]), .o5 (o_byte[5]), .o4 (o_byte[4]),
    .o3 (o_byte[3]), .o2 (o_byte[2]), .o1 (o_byte[1]), .o0 (o_byte[0]),
    .high (high_o)
  );

  // Behavioural model: plain integer rotation, whole cipher in one call.
  function automatic logic [7:0] rot_left(input logic [7:0] v, input int n);
    int t;
    t = int'(v);
    for (int i = 0; i < n; i++) t = ((t << 1) | (t >> 7)) & 255;
    return 8'(t);
  endfunction

  function automatic logic [7:0] enc_model(input logic [7:0] d, input logic [7:0] k);
    logic [7:0] x;
    x = d;
    for (int r = 0; r < 4; r++) x = rot_left(x ^ rot_left(k, r), 1);
    return x;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Present one byte for one edge; the scoreboard front is due on O after it.
  task automatic step(input logic s, input logic [7:0] d, input logic [7:0] k,
                      input logic [7:0] exp, input string tag);
    logic [7:0] e;
    string      t;
    tb_bus.sel = s;
    tb_bus.x   = d;
    tb_bus.key = k;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    if (exp_q.size() == 4) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, o_byte, e);
      if (t == "rt_enc") ct_q.push_back(o_byte);
    end
  endtask

  // One reset edge with random inputs present; pipeline then holds zeros.
  task automatic do_reset();
    rst        = 1'b1;
    tb_bus.sel = 1'($urandom_range(0, 1));
    tb_bus.x   = 8'($urandom_range(0, 255));
    tb_bus.key = 8'($urandom_range(0, 255));
    check("high_in_rst", {7'd0, high_o}, 8'd1);
    @(posedge clk);
    #1;
    check("rst_o_zero", o_byte, 8'h00);
    check("rst_high", {7'd0, high_o}, 8'd1);
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      tag_q.push_back("post_rst_zero");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 8'h00, 8'h00, "drain");
  endtask

  initial begin
    rst        = 1'b1;
    tb_bus.sel = 1'b0;
    tb_bus.x   = 8'h00;
    tb_bus.key = 8'h00;
    tb_bus.rnd = 2'd0;
    tb_bus.y   = 8'h00;
    @(posedge clk);
    #1;
    do_reset();

    // Directed vectors, issued back to back.
    step(1'b1, 8'h84, 8'h18, 8'h48, "enc_84_k18");
    step(1'b0, 8'hD2, 8'h18, 8'h2D, "dec_D2_k18");
    step(1'b1, 8'h2D, 8'h18, 8'hD2, "enc_2D_k18");
    step(1'b1, 8'h01, 8'h00, 8'h10, "zkey_enc");
    step(1'b0, 8'h10, 8'h00, 8'h01, "zkey_dec");
    drain();

    // Reset while bytes are in flight: they must never appear on O.
    step(1'b1, 8'h55, 8'hAA, enc_model(8'h55, 8'hAA), "flushed_a");
    step(1'b1, 8'hC3, 8'h3C, enc_model(8'hC3, 8'h3C), "flushed_b");
    do_reset();
    step(1'b1, 8'h84, 8'h18, 8'h48, "post_flush_enc");
    drain();

    // Random round trip: encrypt through the DUT, then decrypt its output.
    for (int i = 0; i < 1000; i++) begin
      d_arr[i] = 8'($urandom_range(0, 255));
      k_arr[i] = 8'($urandom_range(0, 255));
      step(1'b1, d_arr[i], k_arr[i], enc_model(d_arr[i], k_arr[i]), "rt_enc");
    end
    drain();
    check("rt_ct_count", 8'(ct_q.size() == 1000), 8'd1);
    for (int i = 0; i < 1000; i++) begin
      if (i < ct_q.size()) step(1'b0, ct_q[i], k_arr[i], d_arr[i], "rt_dec");
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
